// File: rtl/t05_register_file_sb.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// pending scoreboard used by decode to stall on operands still in flight.
module t05_register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     write_i,
  input  logic [ADDR_W-1:0]        rd_i,
  input  logic [DATA_W-1:0]        reg_write_i,
  input  logic [NUM_RD*ADDR_W-1:0] rs_i,
  output logic [NUM_RD*DATA_W-1:0] reg_rd_o,
  output logic [NUM_RD-1:0]        busy_o,
  input  logic                     rsv_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          pend_cnt_o,
  output logic                     any_pend_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic write_legal, rsv_legal;
  logic cnt_inc, cnt_dec;

  assign write_legal = write_i && ((rd_i != '0) || (ZERO_REG == 0));
  assign rsv_legal   = rsv_i && ((rsv_addr_i != '0) || (ZERO_REG == 0));

  // A same-cycle reservation of the written register wins, so that write does not decrement.
  assign cnt_inc = rsv_legal && !pend_q[rsv_addr_i];
  assign cnt_dec = write_legal && pend_q[rd_i] && !(rsv_legal && (rsv_addr_i == rd_i));

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (write_legal) pend_d[rd_i] = 1'b0;
      if (rsv_legal)   pend_d[rsv_addr_i] = 1'b1;
      if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + CNT_ONE;
      else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (write_legal) regs_q[rd_i] <= reg_write_i;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              zero;

    assign addr = rs_i[g*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && write_legal && (rd_i == addr);
    assign zero = (ZERO_REG != 0) && (addr == '0);

    assign reg_rd_o[g*DATA_W +: DATA_W] = zero ? '0 : (hit ? reg_write_i : regs_q[addr]);
    assign busy_o[g] = !zero && !hit && pend_q[addr];
  end

  assign pend_cnt_o = cnt_q;
  assign any_pend_o = (cnt_q != '0);

endmodule

// File: doc/t05_register_file_sb.md
Name: t05_register_file_sb

Overview:
Parametrised successor to the team's 32x32 integer register file. It adds N read ports, optional same-cycle write-to-read bypass, and a per-register pending scoreboard. The scoreboard lets the decode stage detect load-use and multi-cycle hazards. It sits between decode (read, reserve) and writeback (write, clear) in the t05 core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending
BYPASS, 1, 1 = a write in the same cycle is forwarded to matching read ports

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; synchronous and active-high: clears all registers, pending bits and counter on the clk edge where rst=1
write  in  1  writeback enable
rd  in  ADDR_W  writeback address
reg_write  in  DATA_W  writeback data
rs  in  NUM_RD*ADDR_W  read addresses; port i = rs[i*ADDR_W +: ADDR_W]
reg_rd  out  NUM_RD*DATA_W  read data; port i = reg_rd[i*DATA_W +: DATA_W]
busy  out  NUM_RD  busy[i]=1: operand on port i is not yet valid; decode must stall
rsv  in  1  reserve: mark rsv_addr as pending (instruction issued with a long-latency destination)
rsv_addr  in  ADDR_W  register to reserve
flush  in  1  clear all pending bits (pipeline flush); register contents are kept
pend_cnt  out  ADDR_W+1  number of registers currently pending
any_pend  out  1  pend_cnt != 0

Behaviour:
- Reset: all registers = 0, pending[] = 0, pend_cnt = 0, any_pend = 0. Combinational outputs follow from state: reg_rd = 0 and busy = 0 while reset state holds.
- Storage: write=1 and (rd!=0 or ZERO_REG=0) -> reg[rd] <= reg_write at the next edge. With ZERO_REG=1, a write to 0 is ignored.
- Read (combinational, 0 latency): reg_rd[i] = reg[rs[i]].
  - BYPASS=1 and write=1 and rd==rs[i] and the write is legal -> reg_rd[i] = reg_write.
  - ZERO_REG=1 and rs[i]==0 -> reg_rd[i] = 0 always.
- Scoreboard, evaluated per edge in this priority order:
  - rst: everything cleared.
  - flush: all pending bits cleared. rsv in the same cycle is dropped. The write still updates data.
  - Otherwise:
    - a legal write clears pending[rd];
    - rsv=1 sets pending[rsv_addr], except address 0 when ZERO_REG=1.
    - write and rsv to the same address in the same cycle -> pending stays/becomes 1 (the new reservation wins).
- Re-reserving an already-pending register: bit stays 1, count unchanged.
- Writing a register that is not pending: data updated, count unchanged.
- busy[i] = pending[rs[i]], combinational.
  - BYPASS=1: busy[i] is suppressed when a legal write to rs[i] happens in the same cycle.
  - BYPASS=0: busy[i] stays set until the cycle after the write.
  - Register 0 is never busy when ZERO_REG=1.
- pend_cnt: registered; equals the popcount of pending[] after each edge. Update it as an incremental +1/-1/0 per cycle (flush -> 0). Must never over/underflow; the maximum is 2**ADDR_W.
- No other outputs are registered; read data and busy carry no pipeline latency.

Test Plan:
- Reset then read -> assert rst 1 cycle; rs={3,0} -> reg_rd={0,0}, busy=0, pend_cnt=0.
- Write/read and x0 -> write reg 5=0xDEADBEEF, next cycle rs0=5 -> 0xDEADBEEF. Write reg 0=0x1234 -> reading reg 0 returns 0.
- Bypass -> write rd=7, data 0xA5A5A5A5 with rs1=7 in the same cycle -> reg_rd port1=0xA5A5A5A5. With BYPASS=0 the same stimulus returns the old value 0 and busy1 stays set if 7 was pending.
- Scoreboard -> rsv 9, next cycle rs0=9 -> busy0=1, pend_cnt=1. Write rd=9 data 0x42: same cycle busy0=0 (BYPASS=1) and reg_rd=0x42; next cycle pend_cnt=0.
- Simultaneous write+rsv same address -> pending 4, then write rd=4 and rsv 4 in one cycle -> pending[4]=1, pend_cnt=1. Also rsv 0 -> no change.
- Flush -> reserve 1,2,3 (pend_cnt=3), then flush with rsv 6 -> pend_cnt=0, all busy=0, register data intact. Also rst mid-sequence -> all cleared on that edge.
